// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the datapath/memory.
// master: controller (drives strobes/selects, reads opcode and zero).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;

  modport master (
    input  opcode, zero,
    output pcwrite, pcwritecond, iord, memwrite,
    output irwrite, regwrite, alusrca,
    output regdst, memtoreg, alusrcb, aluop, pcsource
  );

  modport slave (
    output opcode, zero,
    input  pcwrite, pcwritecond, iord, memwrite,
    input  irwrite, regwrite, alusrca,
    input  regdst, memtoreg, alusrcb, aluop, pcsource
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of the multicycle MIPS core.
// Ports: clk, reset (async, active-low), bus (master modport:
// opcode/zero in, datapath strobes and selects out), state,
// instr_count (retired count, N bits), illegal (sticky).
// Option: MC_JAL_EN enables the JAL state for opcode 000011.
module multicycle_control #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus,
  output logic [3:0]           state,
  output logic [N-1:0]         instr_count,
  output logic                 illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
`ifdef MC_JAL_EN
    JAL    = 4'd12,
`endif
    JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_JAL_EN
  localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

  state_t st;
  state_t nxt;
  ctrl_t  ctl;
  logic   bad_op;
  logic   retire;
  logic   is_mem;
  logic   is_r;
  logic   is_beq;
  logic   is_addi;
  logic   is_j;
`ifdef MC_JAL_EN
  logic   is_jal;
  assign is_jal = bus.opcode == OP_JAL;
`endif

  assign is_mem  = bus.opcode == OP_LW ||
                   bus.opcode == OP_SW;
  assign is_r    = bus.opcode == OP_R;
  assign is_beq  = bus.opcode == OP_BEQ;
  assign is_addi = bus.opcode == OP_ADDI;
  assign is_j    = bus.opcode == OP_J;

  // Moore output table, looked up for the state being entered
  // so the outputs come straight from flops.
  function automatic ctrl_t ctrl_of(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1;
        c.alusrcb = 2'b01;
        c.pcwrite = 1'b1;
      end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD: c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 2'b01;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      REXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      RWB: begin
        c.regdst   = 2'b01;
        c.regwrite = 1'b1;
      end
      BEQ: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcsource    = 2'b01;
        c.pcwritecond = 1'b1;
      end
      IEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      IWB: c.regwrite = 1'b1;
      JUMP: begin
        c.pcsource = 2'b10;
        c.pcwrite  = 1'b1;
      end
`ifdef MC_JAL_EN
      JAL: begin
        c.pcsource = 2'b10;
        c.pcwrite  = 1'b1;
        c.regdst   = 2'b10;
        c.memtoreg = 2'b10;
        c.regwrite = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt    = FETCH;
    bad_op = 1'b0;
    case (st)
      FETCH: nxt = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_mem:  nxt = MEMADR;
          is_r:    nxt = REXEC;
          is_beq:  nxt = BEQ;
          is_addi: nxt = IEXEC;
          is_j:    nxt = JUMP;
`ifdef MC_JAL_EN
          is_jal:  nxt = JAL;
`endif
          default: begin
            nxt    = FETCH;
            bad_op = 1'b1;
          end
        endcase
      end
      MEMADR: nxt = (bus.opcode == OP_SW) ?
                    MEMWR : MEMRD;
      MEMRD:  nxt = MEMWB;
      REXEC:  nxt = RWB;
      IEXEC:  nxt = IWB;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (st)
      MEMWB, MEMWR, RWB, BEQ,
      IWB, JUMP: retire = 1'b1;
`ifdef MC_JAL_EN
      JAL: retire = 1'b1;
`endif
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= FETCH;
      ctl         <= ctrl_of(FETCH);
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      st  <= nxt;
      ctl <= ctrl_of(nxt);
      if (retire)
        instr_count <= instr_count + N'(1);
      if (bad_op)
        illegal <= 1'b1;
    end
  end

  // PC and IR writes must not fire while reset is held.
  assign bus.pcwrite     = ctl.pcwrite & reset;
  assign bus.irwrite     = ctl.irwrite & reset;
  assign bus.pcwritecond = ctl.pcwritecond;
  assign bus.iord        = ctl.iord;
  assign bus.memwrite    = ctl.memwrite;
  assign bus.regwrite    = ctl.regwrite;
  assign bus.alusrca     = ctl.alusrca;
  assign bus.regdst      = ctl.regdst;
  assign bus.memtoreg    = ctl.memtoreg;
  assign bus.alusrcb     = ctl.alusrcb;
  assign bus.aluop       = ctl.aluop;
  assign bus.pcsource    = ctl.pcsource;
  assign state           = st;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM of the multicycle MIPS processor and the initiator side of the unified instruction/data memory. It sequences every instruction through fetch, decode, execute, memory and writeback, and drives the memory strobes (`memwrite`, `irwrite`, `iord`) plus all datapath multiplexer and register-enable selects. It also keeps a retired-instruction counter and a sticky illegal-opcode flag for debug.

## Interface
- `N`, default 32: width of `instr_count`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low; 0 forces FETCH and clears all registers.
- `opcode` input 6: IR[31:26], valid from DECODE onward.
- `zero` input 1: ALU zero flag, sampled in BEQ.
- `pcwrite`, `pcwritecond`, `iord`, `memwrite`, `irwrite`, `regwrite`, `alusrca` output 1 each: datapath enables and selects.
- `regdst` output 2: write register select. 00 = rt, 01 = rd, 10 = $31.
- `memtoreg` output 2: write data select. 00 = ALUOut, 01 = MDR, 10 = PC.
- `alusrcb` output 2: ALU B select. 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `aluop` output 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `pcsource` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` output 4: current state encoding.
- `instr_count` output N: number of retired instructions.
- `illegal` output 1: sticky flag, set on an unknown opcode.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BEQ=8, IEXEC=9, IWB=10, JUMP=11, JAL=12. Codes 13–15 go to FETCH.
- Moore outputs. Any control output not listed for a state is 0 in that state.
- FETCH: `iord`=0, `irwrite`=1, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsource`=00, `pcwrite`=1. Next state is DECODE.
- DECODE: `alusrcb`=11, `aluop`=00. Next state depends on `opcode`:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 → REXEC.
  - 000100 → BEQ.
  - 001000 → IEXEC.
  - 000010 → JUMP.
  - 000011 → JAL.
  - Any other value → FETCH and set `illegal`.
- MEMADR: `alusrca`=1, `alusrcb`=10. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1. Memory read is combinational; MDR captures at the end of this cycle. Next is MEMWB.
- MEMWB: `regdst`=00, `memtoreg`=01, `regwrite`=1. Next is FETCH.
- MEMWR: `iord`=1, `memwrite`=1. Next is FETCH.
- REXEC: `alusrca`=1, `alusrcb`=00, `aluop`=10. Next is RWB.
- RWB: `regdst`=01, `memtoreg`=00, `regwrite`=1. Next is FETCH.
- BEQ: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsource`=01, `pcwritecond`=1. Next is FETCH.
- IEXEC: `alusrca`=1, `alusrcb`=10, `aluop`=00. Next is IWB.
- IWB: `regdst`=00, `memtoreg`=00, `regwrite`=1. Next is FETCH.
- JUMP: `pcsource`=10, `pcwrite`=1. Next is FETCH.
- JAL: `pcsource`=10, `pcwrite`=1, `regdst`=10, `memtoreg`=10, `regwrite`=1. Next is FETCH.
- Retire states are MEMWB, MEMWR, RWB, BEQ, IWB, JUMP and JAL.
  - `instr_count` increments by 1 on the clock edge that leaves a retire state.
  - The count wraps modulo 2^N; all-ones increments to 0.
  - Illegal opcodes do not retire.
- `illegal` is set on the DECODE→FETCH edge for an unknown opcode. It is cleared only by reset.

## Timing
- Reset (`reset`=0), asynchronous: `state`=FETCH(0), `instr_count`=0, `illegal`=0.
- During reset, outputs are the FETCH values; `pcwrite` and `irwrite` are gated to 0 while `reset`=0.
- Release: the first rising edge with `reset`=1 executes FETCH.
- Reset asserted mid-instruction aborts immediately: no partial `memwrite` or `regwrite` after assertion, and the count is not incremented.
- Latency in cycles, including FETCH:
  - lw 5.
  - sw, R-type and addi 4.
  - beq, j and jal 3.
  - illegal 2.
- `memwrite` is high for exactly one cycle per sw, with `iord`=1 in the same cycle.
- `irwrite` is high only in FETCH. The IR must stay stable from DECODE until the next FETCH.
- `zero` is sampled only during BEQ; the PC updates at the end of that cycle when `zero`=1.

## Configuration
- `MC_JAL_EN` defined: opcode 000011 is decoded to the JAL state.
- `MC_JAL_EN` undefined:
  - The JAL state is removed.
  - Opcode 000011 is illegal: DECODE → FETCH, `illegal` set, count not incremented.
  - `regdst` and `memtoreg` never take the value 10.

## Test plan
- Reset held low for 3 cycles with opcode and zero at arbitrary values → `state`=0, `instr_count`=0, `illegal`=0, and `pcwrite`, `irwrite`, `memwrite`, `regwrite` all 0.
- Sequence add, lw, sw (opcodes 000000, 100011, 101011) → state traces 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5. `memwrite` pulses once; `instr_count`=3 after 13 cycles.
- beq with `zero`=1, then beq with `zero`=0 → `pcwritecond`=1 and `pcsource`=01 in state 8 both times; count +2.
- jal with `MC_JAL_EN` on → state 12 shows `regdst`=10, `memtoreg`=10, `regwrite`=1, `pcwrite`=1. With the macro off → `illegal`=1 after 2 cycles and count unchanged.
- Opcode 111111 → DECODE→FETCH, `illegal` goes to 1 and stays set through a following valid add.
- Reset pulled low during MEMWR, then `instr_count` preloaded to all-ones via forced retires → `memwrite` drops asynchronously and `state`=0; the next retire wraps the count to 0.
